// File: rtl/preio_f2a_arbiter.sv
// Round-robin arbiter that serialises one fabric requester word at a time onto a
// QL_PREIO F2A pad lane as a frame: start bit, grant id (MSB-first), payload (LSB-first), gap.
module preio_f2a_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned IDLE_GAP = 1,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      pad_clk,
    input  logic                      pad_resetn,
    input  logic                      arb_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      pad_outpad,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      frame_done
);

    localparam int unsigned MAX_ID_DATA = (ID_W > DATA_W) ? ID_W : DATA_W;
    localparam int unsigned MAX_CNT     = (MAX_ID_DATA > IDLE_GAP) ? MAX_ID_DATA : IDLE_GAP;
    localparam int unsigned CNT_W       = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StId,
        StData,
        StGap
    } state_t;

    state_t              r_state;
    state_t              w_state_d;
    logic [ID_W-1:0]     r_last;
    logic [ID_W-1:0]     w_last_d;
    logic [ID_W-1:0]     r_grant;
    logic [ID_W-1:0]     w_grant_d;
    logic [ID_W-1:0]     r_id_sh;
    logic [ID_W-1:0]     w_id_sh_d;
    logic [DATA_W-1:0]   r_data_sh;
    logic [DATA_W-1:0]   w_data_sh_d;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_d;
    logic                r_pad;
    logic                w_pad_d;
    logic                r_done;
    logic                w_done_d;

    logic                w_found;
    logic [ID_W-1:0]     w_winner;
    logic [NUM_REQ-1:0]  w_onehot;
    logic [DATA_W-1:0]   w_win_data;
    logic                w_accept;
    int                  w_dist;
    int                  w_best;

    // Winner is the valid requester with the smallest circular distance above last_grant.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_onehot   = '0;
        w_win_data = '0;
        w_dist     = 0;
        w_best     = int'(NUM_REQ);
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (j > int'(r_last)) begin
                w_dist = j - int'(r_last) - 1;
            end else begin
                w_dist = j + int'(NUM_REQ) - int'(r_last) - 1;
            end
            if (req_valid[j] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_found     = 1'b1;
                w_winner    = ID_W'(j);
                w_onehot    = '0;
                w_onehot[j] = 1'b1;
                w_win_data  = req_data[j*DATA_W +: DATA_W];
            end
        end
    end

    assign w_accept  = pad_resetn && arb_en && w_found && (r_state == StIdle);
    assign req_ready = w_accept ? w_onehot : '0;

    always_comb begin
        w_state_d   = r_state;
        w_last_d    = r_last;
        w_grant_d   = r_grant;
        w_id_sh_d   = r_id_sh;
        w_data_sh_d = r_data_sh;
        w_cnt_d     = r_cnt;
        w_pad_d     = 1'b0;
        w_done_d    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d   = StStart;
                    w_last_d    = w_winner;
                    w_grant_d   = w_winner;
                    w_id_sh_d   = w_winner;
                    w_data_sh_d = w_win_data;
                    w_pad_d     = 1'b1;
                end
            end
            StStart: begin
                w_state_d = StId;
                w_cnt_d   = CNT_W'(ID_W - 1);
                w_pad_d   = r_id_sh[ID_W-1];
                w_id_sh_d = r_id_sh << 1;
            end
            StId: begin
                if (r_cnt == '0) begin
                    w_state_d   = StData;
                    w_cnt_d     = CNT_W'(DATA_W - 1);
                    w_pad_d     = r_data_sh[0];
                    w_data_sh_d = r_data_sh >> 1;
                    w_done_d    = (DATA_W == 1);
                end else begin
                    w_cnt_d   = r_cnt - CNT_W'(1);
                    w_pad_d   = r_id_sh[ID_W-1];
                    w_id_sh_d = r_id_sh << 1;
                end
            end
            StData: begin
                if (r_cnt == '0) begin
                    w_state_d = StGap;
                    w_cnt_d   = CNT_W'(IDLE_GAP - 1);
                end else begin
                    w_cnt_d     = r_cnt - CNT_W'(1);
                    w_pad_d     = r_data_sh[0];
                    w_data_sh_d = r_data_sh >> 1;
                    // Flag the cycle that carries the final payload bit.
                    w_done_d    = (r_cnt == CNT_W'(1));
                end
            end
            StGap: begin
                if (r_cnt == '0) begin
                    w_state_d = StIdle;
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge pad_clk or negedge pad_resetn) begin
        if (!pad_resetn) begin
            r_state   <= StIdle;
            r_last    <= ID_W'(NUM_REQ - 1);
            r_grant   <= '0;
            r_id_sh   <= '0;
            r_data_sh <= '0;
            r_cnt     <= '0;
            r_pad     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_last    <= w_last_d;
            r_grant   <= w_grant_d;
            r_id_sh   <= w_id_sh_d;
            r_data_sh <= w_data_sh_d;
            r_cnt     <= w_cnt_d;
            r_pad     <= w_pad_d;
            r_done    <= w_done_d;
        end
    end

    assign pad_outpad = r_pad;
    assign frame_done = r_done;
    assign grant_id   = r_grant;
    assign busy       = (r_state != StIdle);

endmodule

// File: tb/tb_preio_f2a_arbiter.sv
// Bench for preio_f2a_arbiter: default-parameter instance driven from a vector table and
// hand sequences, plus a NUM_REQ=2/DATA_W=1/IDLE_GAP=15 corner instance.
module tb_preio_f2a_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arb_en;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        pad;
    logic        busy;
    logic [1:0]  grant_id;
    logic        done;

    logic [1:0]  c_valid;
    logic [1:0]  c_data;
    logic [1:0]  c_ready;
    logic        c_pad;
    logic        c_busy;
    logic [0:0]  c_grant;
    logic        c_done;

    always #5 clk = ~clk;

    preio_f2a_arbiter #(.NUM_REQ(4), .DATA_W(8), .IDLE_GAP(1)) u_dut (
        .pad_clk    (clk),
        .pad_resetn (rst_n),
        .arb_en     (arb_en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .pad_outpad (pad),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (done)
    );

    preio_f2a_arbiter #(.NUM_REQ(2), .DATA_W(1), .IDLE_GAP(15)) u_corner (
        .pad_clk    (clk),
        .pad_resetn (rst_n),
        .arb_en     (arb_en),
        .req_valid  (c_valid),
        .req_data   (c_data),
        .req_ready  (c_ready),
        .pad_outpad (c_pad),
        .busy       (c_busy),
        .grant_id   (c_grant),
        .frame_done (c_done)
    );

    typedef struct {
        logic pad;
        logic done;
        logic busy;
    } exp_t;

    typedef struct {
        logic        en;
        logic [3:0]  valid;
        logic [31:0] data;
        int          exp_w;
        int          drop_at;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line for one default-parameter frame, its gap cycle and the following idle cycle.
    function automatic void push_frame(input int w, input logic [7:0] d);
        logic [1:0] wid;
        wid = 2'(w);
        sb.push_back('{pad: 1'b1, done: 1'b0, busy: 1'b1});
        for (int b = 1; b >= 0; b--) sb.push_back('{pad: wid[b], done: 1'b0, busy: 1'b1});
        for (int i = 0; i < 8; i++) sb.push_back('{pad: d[i], done: (i == 7), busy: 1'b1});
        sb.push_back('{pad: 1'b0, done: 1'b0, busy: 1'b1});
        sb.push_back('{pad: 1'b0, done: 1'b0, busy: 1'b0});
    endfunction

    task automatic drain(input int drop_at);
        exp_t e;
        int   idx = 0;
        int   n   = sb.size();
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("pad[%0d]", idx), pad, e.pad);
            check($sformatf("frame_done[%0d]", idx), done, e.done);
            check($sformatf("busy[%0d]", idx), busy, e.busy);
            check($sformatf("ready_zero[%0d]", idx), req_ready, 0);
            if (idx == drop_at) arb_en = 1'b0;
            if (idx == n - 2) req_valid = '0;
            idx++;
        end
    endtask

    task automatic send_frame(input vec_t v);
        int t = 0;
        @(negedge clk);
        arb_en    = v.en;
        req_valid = v.valid;
        req_data  = v.data;
        #1;
        while (req_ready == '0 && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (req_ready == '0) begin
            check("accept_timeout", 0, 1);
            return;
        end
        check("ready_onehot", req_ready, 32'(1) << v.exp_w);
        push_frame(v.exp_w, v.data[v.exp_w*8 +: 8]);
        @(posedge clk);
        #1;
        req_valid = v.valid & ~(4'(1) << v.exp_w);
        drain(v.drop_at);
        check("grant_id_hold", grant_id, v.exp_w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   g_idx[$];
        int   g_cyc[$];
        int   k;
        int   t;
        exp_t e;

        vecs[0] = '{en: 1'b1, valid: 4'b0100, data: 32'h00A5_0000, exp_w: 2, drop_at: -1};
        vecs[1] = '{en: 1'b1, valid: 4'b1001, data: 32'h3C00_005A, exp_w: 3, drop_at: -1};
        vecs[2] = '{en: 1'b1, valid: 4'b1001, data: 32'h8100_0096, exp_w: 0, drop_at: -1};
        vecs[3] = '{en: 1'b1, valid: 4'b1111, data: 32'hDEAD_BEEF, exp_w: 1, drop_at: -1};
        vecs[4] = '{en: 1'b1, valid: 4'b0011, data: 32'h1234_5678, exp_w: 0, drop_at: -1};
        vecs[5] = '{en: 1'b1, valid: 4'b0001, data: 32'h0000_00FF, exp_w: 0, drop_at: -1};
        vecs[6] = '{en: 1'b1, valid: 4'b1110, data: 32'hC3A5_0F00, exp_w: 1, drop_at: -1};
        vecs[7] = '{en: 1'b1, valid: 4'b0101, data: 32'h0080_0001, exp_w: 2, drop_at: 5};

        rst_n     = 1'b0;
        arb_en    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        c_valid   = '0;
        c_data    = '0;
        repeat (2) @(negedge clk);
        check("rst_pad", pad, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_grant", grant_id, 0);
        arb_en    = 1'b1;
        req_valid = 4'b1111;
        #1;
        check("rst_ready", req_ready, 0);
        arb_en    = 1'b0;
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) send_frame(vecs[i]);

        // arb_en is now low: requests must be ignored until it returns.
        @(negedge clk);
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("en_low_ready", req_ready, 0);
            check("en_low_busy", busy, 0);
        end
        arb_en   = 1'b1;
        req_data = 32'hFF00_0000;
        #1;
        check("en_same_cycle_ready", req_ready, 4'b1000);

        // Reset during payload bit 5 of requester 3's frame.
        @(posedge clk);
        repeat (8) @(negedge clk);
        check("pre_rst_pad", pad, 1);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pad", pad, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_grant", grant_id, 0);
        check("mid_rst_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // All four held valid: expect grants 0,1,2,3 every 13 cycles.
        for (int c = 0; c < 52; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check($sformatf("ready_onehot0[%0d]", c), $onehot0(req_ready), 1);
            if (req_ready != '0) begin
                k = 0;
                for (int b = 0; b < 4; b++) if (req_ready[b]) k = b;
                g_idx.push_back(k);
                g_cyc.push_back(c);
            end
        end
        @(negedge clk);
        req_valid = '0;
        check("fair_grants", g_idx.size(), 4);
        for (int i = 0; i < g_idx.size(); i++) begin
            check($sformatf("fair_order[%0d]", i), g_idx[i], i);
            if (i > 0) check($sformatf("fair_spacing[%0d]", i), g_cyc[i] - g_cyc[i-1], 13);
        end

        // Corner instance: two back-to-back 3-bit frames, 19 cycles apart.
        @(negedge clk);
        c_data  = 2'b10;
        c_valid = 2'b11;
        #1;
        t = 0;
        while (c_ready == '0 && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("corner_first_ready", c_ready, 2'b01);
        for (int s = 1; s < 38; s++) begin
            int p;
            int w;
            p = s % 19;
            w = s / 19;
            if (p == 0) sb.push_back('{pad: 1'b0, done: 1'b0, busy: 1'b0});
            else if (p == 1) sb.push_back('{pad: 1'b1, done: 1'b0, busy: 1'b1});
            else if (p == 2) sb.push_back('{pad: (w == 1), done: 1'b0, busy: 1'b1});
            else if (p == 3) sb.push_back('{pad: c_data[w], done: 1'b1, busy: 1'b1});
            else sb.push_back('{pad: 1'b0, done: 1'b0, busy: 1'b1});
        end
        for (int s = 1; s < 38; s++) begin
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("c_pad[%0d]", s), c_pad, e.pad);
            check($sformatf("c_done[%0d]", s), c_done, e.done);
            check($sformatf("c_busy[%0d]", s), c_busy, e.busy);
            if (s == 19) check("corner_second_ready", c_ready, 2'b10);
            else check($sformatf("c_ready_zero[%0d]", s), c_ready, 0);
        end
        @(negedge clk);
        c_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
